// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants and state encoding for the WISHBONE round-robin arbiter
package wb_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2
    } arb_state_e;

    // WISHBONE address width shared by every master and the slave port
    localparam int WB_AWIDTH = 32;

    // Default bus-hang limit in STB cycles without ACK
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin winner selection from a last-grant pointer
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [N-1:0]    onehot_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    int              k;
    logic [IDXW-1:0] ki;

    // Scan from the slot after the last winner, wrapping once, and take the first requester
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        k        = 0;
        ki       = '0;
        for (int i = 1; i <= N; i++) begin
            k = int'(last_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            ki = IDXW'(k);
            if (!valid_o && req_i[ki]) begin
                valid_o      = 1'b1;
                onehot_o[ki] = 1'b1;
                idx_o        = ki;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - N-master to 1-slave WISHBONE arbiter with round-robin fairness and hang watchdog
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int WB_DWIDTH   = 32,
    parameter int WB_SWIDTH   = 4,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int TO_WIDTH    = 8
) (
    input  logic                             i_wb_clk,
    input  logic                             i_arst_n,
    input  logic [NUM_MASTERS*WB_AWIDTH-1:0] i_m_wb_adr,
    input  logic [NUM_MASTERS*WB_SWIDTH-1:0] i_m_wb_sel,
    input  logic [NUM_MASTERS-1:0]           i_m_wb_we,
    input  logic [NUM_MASTERS*WB_DWIDTH-1:0] i_m_wb_dat,
    input  logic [NUM_MASTERS-1:0]           i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]           i_m_wb_stb,
    output logic [WB_DWIDTH-1:0]             o_m_wb_dat,
    output logic [NUM_MASTERS-1:0]           o_m_wb_ack,
    output logic [NUM_MASTERS-1:0]           o_m_wb_err,
    output logic [WB_AWIDTH-1:0]             o_s_wb_adr,
    output logic [WB_SWIDTH-1:0]             o_s_wb_sel,
    output logic                             o_s_wb_we,
    output logic [WB_DWIDTH-1:0]             o_s_wb_dat,
    output logic                             o_s_wb_cyc,
    output logic                             o_s_wb_stb,
    input  logic [WB_DWIDTH-1:0]             i_s_wb_dat,
    input  logic                             i_s_wb_ack,
    output logic [NUM_MASTERS-1:0]           o_grant,
    output logic                             o_timeout
);

    localparam int IDXW = $clog2(NUM_MASTERS);
    // wdog_q counts completed STB cycles without ACK; the TIMEOUT-th such cycle aborts
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    arb_state_e              state_q;
    logic [NUM_MASTERS-1:0]  grant_q;
    logic [IDXW-1:0]         last_q;
    logic [TO_WIDTH-1:0]     wdog_q;

    logic [NUM_MASTERS-1:0]  pick_onehot;
    logic [IDXW-1:0]         pick_idx;
    logic                    pick_valid;

    logic [WB_AWIDTH-1:0]    mux_adr;
    logic [WB_SWIDTH-1:0]    mux_sel;
    logic [WB_DWIDTH-1:0]    mux_dat;
    logic                    mux_we;
    logic                    mux_cyc;
    logic                    mux_stb;
    logic                    granted;

    rr_pick #(
        .N    (NUM_MASTERS),
        .IDXW (IDXW)
    ) u_pick (
        .req_i    (i_m_wb_cyc),
        .last_i   (last_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // AND-OR mux of the granted master's fields; grant_q is one-hot or zero
    always_comb begin
        mux_adr = '0;
        mux_sel = '0;
        mux_dat = '0;
        mux_we  = 1'b0;
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) begin
                mux_adr = mux_adr | i_m_wb_adr[m*WB_AWIDTH +: WB_AWIDTH];
                mux_sel = mux_sel | i_m_wb_sel[m*WB_SWIDTH +: WB_SWIDTH];
                mux_dat = mux_dat | i_m_wb_dat[m*WB_DWIDTH +: WB_DWIDTH];
                mux_we  = mux_we  | i_m_wb_we[m];
                mux_cyc = mux_cyc | i_m_wb_cyc[m];
                mux_stb = mux_stb | i_m_wb_stb[m];
            end
        end
    end

    // Slave controls are gated by the registered state so reset drops them at once
    assign granted    = (state_q == ST_GRANT);
    assign o_s_wb_adr = mux_adr;
    assign o_s_wb_sel = mux_sel;
    assign o_s_wb_dat = mux_dat;
    assign o_s_wb_we  = granted & mux_we;
    assign o_s_wb_cyc = granted & mux_cyc;
    assign o_s_wb_stb = granted & mux_cyc & mux_stb;

    assign o_m_wb_dat = i_s_wb_dat;
    assign o_m_wb_ack = grant_q & {NUM_MASTERS{granted & i_s_wb_ack}};
    assign o_m_wb_err = grant_q & {NUM_MASTERS{state_q == ST_ERR}};
    assign o_timeout  = (state_q == ST_ERR);
    assign o_grant    = grant_q;

    // Arbitration FSM: IDLE picks a winner, GRANT holds it for the whole cycle, ERR aborts a hung transfer
    always_ff @(posedge i_wb_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NUM_MASTERS - 1);
            wdog_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wdog_q <= '0;
                    if (pick_valid) begin
                        grant_q <= pick_onehot;
                        last_q  <= pick_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!mux_cyc) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        wdog_q  <= '0;
                    end else if (o_s_wb_stb && !i_s_wb_ack) begin
                        if (wdog_q == TO_LAST) begin
                            state_q <= ST_ERR;
                            wdog_q  <= '0;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end else begin
                        wdog_q <= '0;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    wdog_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    wdog_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - scoreboard bench for the round-robin WISHBONE arbiter
module tb_wb_rr_arbiter;

    localparam int NM  = 4;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 4;
    localparam int TOW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM*32-1:0]  m_adr;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_we;
    logic [NM*DW-1:0]  m_dat;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [DW-1:0]     o_m_wb_dat;
    logic [NM-1:0]     o_m_wb_ack;
    logic [NM-1:0]     o_m_wb_err;
    logic [31:0]       o_s_wb_adr;
    logic [SW-1:0]     o_s_wb_sel;
    logic              o_s_wb_we;
    logic [DW-1:0]     o_s_wb_dat;
    logic              o_s_wb_cyc;
    logic              o_s_wb_stb;
    logic [DW-1:0]     s_dat;
    logic              s_ack;
    logic [NM-1:0]     o_grant;
    logic              o_timeout;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS (NM),
        .WB_DWIDTH   (DW),
        .WB_SWIDTH   (SW),
        .TIMEOUT     (TMO),
        .TO_WIDTH    (TOW)
    ) dut (
        .i_wb_clk   (clk),
        .i_arst_n   (rst_n),
        .i_m_wb_adr (m_adr),
        .i_m_wb_sel (m_sel),
        .i_m_wb_we  (m_we),
        .i_m_wb_dat (m_dat),
        .i_m_wb_cyc (m_cyc),
        .i_m_wb_stb (m_stb),
        .o_m_wb_dat (o_m_wb_dat),
        .o_m_wb_ack (o_m_wb_ack),
        .o_m_wb_err (o_m_wb_err),
        .o_s_wb_adr (o_s_wb_adr),
        .o_s_wb_sel (o_s_wb_sel),
        .o_s_wb_we  (o_s_wb_we),
        .o_s_wb_dat (o_s_wb_dat),
        .o_s_wb_cyc (o_s_wb_cyc),
        .o_s_wb_stb (o_s_wb_stb),
        .i_s_wb_dat (s_dat),
        .i_s_wb_ack (s_ack),
        .o_grant    (o_grant),
        .o_timeout  (o_timeout)
    );

    typedef struct {
        bit          is_err;
        int          m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic        we;
        logic [3:0]  sel;
    } ev_t;

    int checks = 0;
    int errors = 0;

    // per-master planned accesses for the current round
    int          nacc  [NM];
    logic [31:0] p_adr [NM][4];
    logic [31:0] p_dat [NM][4];
    logic        p_we  [NM][4];
    logic [3:0]  p_sel [NM][4];
    int          p_lat [NM][4];
    int          cur   [NM];
    bit          act   [NM];
    bit          done  [NM];

    ev_t exp_ev[$];
    int  exp_gnt[$];
    int  model_last;
    int  nack;
    logic nxt_ack;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int oh_idx(input logic [NM-1:0] v);
        for (int i = 0; i < NM; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(1, 3));
        if (r == 7) return TMO - 1;
        if (r == 8) return TMO;
        return 50;
    endfunction

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] req);
        checks++;
        if (actual !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, req, $time);
        end
    endtask

    task automatic add_acc(input int m, input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic [3:0] s, input int l);
        p_adr[m][nacc[m]] = a;
        p_dat[m][nacc[m]] = d;
        p_we[m][nacc[m]]  = w;
        p_sel[m][nacc[m]] = s;
        p_lat[m][nacc[m]] = l;
        nacc[m]++;
    endtask

    // Reference: all round requesters raise CYC together and hold it, so grants follow
    // one rotation starting after the previous winner; an access waiting TMO cycles errors out.
    task automatic plan_model();
        int  start;
        int  k;
        ev_t e;
        start = model_last;
        for (int i = 1; i <= NM; i++) begin
            k = (start + i) % NM;
            if (nacc[k] > 0) begin
                exp_gnt.push_back(k);
                model_last = k;
                for (int j = 0; j < nacc[k]; j++) begin
                    e.m      = k;
                    e.adr    = p_adr[k][j];
                    e.dat    = p_dat[k][j];
                    e.we     = p_we[k][j];
                    e.sel    = p_sel[k][j];
                    e.rdata  = rdata_of(p_adr[k][j]);
                    e.is_err = (p_lat[k][j] >= TMO);
                    exp_ev.push_back(e);
                    if (e.is_err) break;
                end
            end
        end
    endtask

    task automatic apply_inputs();
        for (int m = 0; m < NM; m++) begin
            if (act[m] && !done[m]) begin
                m_cyc[m]            = 1'b1;
                m_stb[m]            = 1'b1;
                m_adr[m*32 +: 32]   = p_adr[m][cur[m]];
                m_dat[m*DW +: DW]   = p_dat[m][cur[m]];
                m_we[m]             = p_we[m][cur[m]];
                m_sel[m*SW +: SW]   = p_sel[m][cur[m]];
            end else begin
                m_cyc[m]            = 1'b0;
                m_stb[m]            = 1'b0;
                m_adr[m*32 +: 32]   = $urandom;
                m_dat[m*DW +: DW]   = $urandom;
                m_we[m]             = 1'($urandom);
                m_sel[m*SW +: SW]   = SW'($urandom);
            end
        end
    endtask

    // One bus cycle of master and slave behaviour: observe mid-cycle, drive just after the edge
    task automatic cycle_step();
        int g;
        @(negedge clk);
        nxt_ack = 1'b0;
        if (o_s_wb_cyc && o_s_wb_stb) begin
            if (s_ack) begin
                nack = 0;
            end else begin
                g = oh_idx(o_grant);
                nack++;
                nxt_ack = (nack == p_lat[g][cur[g]]);
            end
        end else begin
            nack = 0;
        end
        for (int m = 0; m < NM; m++) begin
            if (act[m] && !done[m]) begin
                if (o_m_wb_ack[m]) begin
                    cur[m]++;
                    if (cur[m] == nacc[m]) done[m] = 1'b1;
                end else if (o_m_wb_err[m]) begin
                    done[m] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        apply_inputs();
        s_ack = nxt_ack;
        #1;
        s_dat = rdata_of(o_s_wb_adr);
    endtask

    function automatic bit all_done();
        for (int m = 0; m < NM; m++) if (act[m] && !done[m]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic start_round();
        for (int m = 0; m < NM; m++) begin
            act[m]  = (nacc[m] > 0);
            done[m] = 1'b0;
            cur[m]  = 0;
        end
    endtask

    task automatic end_round();
        for (int m = 0; m < NM; m++) begin
            act[m]  = 1'b0;
            nacc[m] = 0;
        end
    endtask

    task automatic run_round();
        int budget;
        plan_model();
        start_round();
        budget = 0;
        do begin
            cycle_step();
            budget++;
        end while (!(all_done() && o_grant == '0) && budget < 300);
        if (budget >= 300) begin
            checks++;
            errors++;
            $display("FAIL round_budget actual=%0d cycles required=below 300", budget);
        end
        end_round();
    endtask

    // Monitor: pops the scoreboard whenever the DUT grants, acks or errors
    initial begin
        int         gap;
        int         eg;
        logic       pto;
        logic [NM-1:0] pg;
        ev_t        e;
        gap = 0;
        pto = 1'b0;
        pg  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap = 0;
                pto = 1'b0;
                pg  = '0;
            end else begin
                if (o_grant != '0 && pg == '0) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_grant", o_grant, '0);
                    end else begin
                        eg = exp_gnt.pop_front();
                        chk("grant", o_grant, 64'(1) << eg);
                        chk("grant_gap", gap, 1);
                    end
                end
                if (o_grant == '0 && m_cyc != '0) gap++;
                else if (o_grant != '0) gap = 0;

                if (o_m_wb_ack != '0 || o_m_wb_err != '0 || o_timeout) begin
                    if (exp_ev.size() == 0) begin
                        chk("unexpected_event", {o_m_wb_ack, o_m_wb_err, o_timeout}, '0);
                    end else begin
                        e = exp_ev.pop_front();
                        if (!e.is_err) begin
                            chk("ack_vec", o_m_wb_ack, 64'(1) << e.m);
                            chk("ack_no_err", {o_m_wb_err, o_timeout}, '0);
                            chk("rdata", o_m_wb_dat, e.rdata);
                            chk("s_adr", o_s_wb_adr, e.adr);
                            chk("s_dat", o_s_wb_dat, e.dat);
                            chk("s_we", o_s_wb_we, e.we);
                            chk("s_sel", o_s_wb_sel, e.sel);
                            chk("s_cyc_stb", {o_s_wb_cyc, o_s_wb_stb}, 2'b11);
                        end else begin
                            chk("err_vec", o_m_wb_err, 64'(1) << e.m);
                            chk("err_timeout", o_timeout, 1'b1);
                            chk("err_no_ack", o_m_wb_ack, '0);
                            chk("err_slave_idle", {o_s_wb_cyc, o_s_wb_stb}, 2'b00);
                        end
                    end
                end
                if (o_timeout) chk("timeout_one_cycle", pto, 1'b0);
                pg  = o_grant;
                pto = o_timeout;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int          budget;
        logic [3:0]  mask;
        int          n;
        rst_n = 1'b0;
        m_adr = '0; m_sel = '0; m_we = '0; m_dat = '0; m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_dat = '0;
        nack = 0; nxt_ack = 1'b0;
        model_last = NM - 1;
        for (int m = 0; m < NM; m++) begin
            nacc[m] = 0; cur[m] = 0; act[m] = 1'b0; done[m] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", o_grant, '0);
        chk("rst_slave_ctl", {o_s_wb_cyc, o_s_wb_stb, o_s_wb_we}, '0);
        chk("rst_ack_err", {o_m_wb_ack, o_m_wb_err}, '0);
        chk("rst_timeout", o_timeout, 1'b0);
        rst_n = 1'b1;

        // single master 2 write
        add_acc(2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 4'hF, 1);
        run_round();

        // all four masters, one access each
        for (int m = 0; m < NM; m++) add_acc(m, 32'h1000 + m, 32'hA000 + m, 1'b0, 4'h3, 1);
        run_round();

        // move pointer to master 0, then master 1 does 3 back-to-back reads while master 0 waits
        add_acc(0, 32'h2000, 32'h0, 1'b1, 4'h1, 2);
        run_round();
        add_acc(1, 32'h3000, 32'h0, 1'b0, 4'hF, 1);
        add_acc(1, 32'h3004, 32'h0, 1'b0, 4'hF, 2);
        add_acc(1, 32'h3008, 32'h0, 1'b0, 4'hF, 1);
        add_acc(0, 32'h3100, 32'h5555_AAAA, 1'b1, 4'hC, 1);
        run_round();

        // hung slave on master 3 among other requesters
        add_acc(1, 32'h4000, 32'h11, 1'b1, 4'hF, 1);
        add_acc(3, 32'h4300, 32'h33, 1'b1, 4'hF, 50);
        add_acc(0, 32'h4400, 32'h44, 1'b0, 4'hF, 1);
        run_round();

        // ack on the last allowed cycle, then an ack one cycle too late
        add_acc(2, 32'h5000, 32'h55, 1'b0, 4'hF, TMO - 1);
        add_acc(2, 32'h5004, 32'h66, 1'b0, 4'hF, TMO);
        run_round();

        // reset in the middle of a granted transfer
        add_acc(2, 32'h6000, 32'h1234_5678, 1'b1, 4'hF, 50);
        plan_model();
        start_round();
        budget = 0;
        while (o_grant == '0 && budget < 10) begin
            cycle_step();
            budget++;
        end
        chk("mid_rst_granted", o_grant, 4'b0100);
        cycle_step();
        cycle_step();
        chk("mid_rst_busy", {o_s_wb_cyc, o_s_wb_stb}, 2'b11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_slave_ctl", {o_s_wb_cyc, o_s_wb_stb, o_s_wb_we}, '0);
        chk("mid_rst_grant", o_grant, '0);
        chk("mid_rst_ack_err_to", {o_m_wb_ack, o_m_wb_err, o_timeout}, '0);
        exp_gnt.delete();
        exp_ev.delete();
        model_last = NM - 1;
        end_round();
        nack  = 0;
        s_ack = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // after reset master 0 wins first; two full rotations
        repeat (2) begin
            for (int m = 0; m < NM; m++) add_acc(m, 32'h7000 + 4 * m, $urandom, 1'b1, 4'hF, 1);
            run_round();
        end

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int m = 0; m < NM; m++) begin
                if (mask[m]) begin
                    n = int'($urandom_range(1, 3));
                    for (int j = 0; j < n; j++)
                        add_acc(m, $urandom, $urandom, 1'($urandom), 4'($urandom), pick_lat());
                end
            end
            run_round();
            n = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++) cycle_step();
        end

        repeat (2) cycle_step();
        chk("grants_drained", exp_gnt.size(), 0);
        chk("events_drained", exp_ev.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
